instr_feeder: RTL and testbench

Instruction/immediate source sitting directly upstream of `simple_proc`. It drives the processor's 9-bit `din` port. Words pushed by the board interface (switch bank + debounced strobe) or a testbench are buffered in a FIFO. The feeder sequences each word onto `din` in step with the processor's one-hot `tick`: the instruction word at the IR-load boundary, then the immediate word for `movi`/`addi` during execute ticks. When no complete instruction is buffered, it issues a NOP (opcode 000), so the free-running processor never executes a half-delivered instruction.

---
 rtl/proc_pkg.sv | 25 ++
 rtl/fifo_sync.sv | 56 +++++
 rtl/instr_feeder.sv | 83 ++++++++
 tb/tb_instr_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcode, tick and word constants for simple_proc and its feeder
package proc_pkg;

    localparam int         WORD_W   = 9;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_MOVI  = 3'b111;
    localparam logic [8:0] NOP_WORD = 9'b000_000_000;

    localparam logic [3:0] T1 = 4'b0001;
    localparam logic [3:0] T2 = 4'b0010;
    localparam logic [3:0] T3 = 4'b0100;
    localparam logic [3:0] T4 = 4'b1000;

    typedef enum logic {
        S_INSTR = 1'b0,
        S_IMM   = 1'b1
    } feed_state_e;

    function automatic logic needs_imm(input logic [2:0] opcode);
        return (opcode == OP_ADDI) || (opcode == OP_MOVI);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock word FIFO with count and sticky overflow flag
module fifo_sync #(
    parameter int DEPTH = 8,
    parameter int W     = 9,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          overflow_o
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          do_pop, do_push;

    // A pop in the same edge frees a slot, so a push into a full FIFO still lands.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            if (push_i && !do_push) overflow_q <= 1'b1;
        end
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/instr_feeder.sv
// rtl/instr_feeder.sv - buffers instruction/immediate words and sequences them onto simple_proc din
module instr_feeder
    import proc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 9,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    tick,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [15:0]   issued
);

    feed_state_e state_q;
    logic [15:0] issued_q;
    logic [W-1:0] head;
    logic         load_boundary, head_imm, issue_ok, pop;

    fifo_sync #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (wr_en),
        .data_i     (wr_data),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (overflow)
    );

    // Any non-one-hot tick is treated as a load boundary so a glitched tick resyncs framing.
    assign load_boundary = !(tick inside {T1, T2, T3});
    assign head_imm      = needs_imm(head[W-1 -: 3]);
    assign issue_ok      = !empty && (!head_imm || (count >= CW'(2)));

    always_comb begin
        din = '0;
        pop = 1'b0;
        case (state_q)
            S_INSTR: begin
                if (issue_ok) din = head;
                pop = issue_ok && load_boundary;
            end
            S_IMM: begin
                din = head;
                pop = (tick == T3) || load_boundary;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INSTR;
            issued_q <= '0;
        end else begin
            case (state_q)
                S_INSTR: begin
                    if (pop) begin
                        issued_q <= issued_q + 16'd1;
                        if (head_imm) state_q <= S_IMM;
                    end
                end
                S_IMM: begin
                    if (pop) state_q <= S_INSTR;
                end
                default: state_q <= S_INSTR;
            endcase
        end
    end

    assign issued = issued_q;

endmodule

// File: tb/tb_instr_feeder.sv
// tb/tb_instr_feeder.sv - scoreboard bench for instr_feeder
module tb_instr_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] tick = 4'b0001;
    logic       wr_en = 1'b0;
    logic [8:0] wr_data = '0;
    logic [8:0] din;
    logic       full, empty, overflow;
    logic [3:0] count;
    logic [15:0] issued;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];
    logic tick_run = 1'b1;
    logic in_imm = 1'b0;

    always #5 clk = ~clk;

    instr_feeder #(.DEPTH(8), .W(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .din      (din),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .issued   (issued)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (tick_run) tick = {tick[2:0], tick[3]};
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic [8:0] w);
        wr_data = w;
        wr_en   = 1'b1;
        step();
    endtask

    task automatic wait_tick(input logic [3:0] t);
        for (int i = 0; i < 8; i++) begin
            if (tick == t) return;
            step();
        end
        check("wait_tick_timeout", {28'd0, tick}, {28'd0, t});
    endtask

    function automatic logic imm_op(input logic [2:0] op);
        return (op == 3'b010) || (op == 3'b111);
    endfunction

    // Monitor: consumes expected words when the processor would latch them.
    always @(negedge clk) begin
        logic lb;
        logic [8:0] e;
        if (rst) begin
            in_imm = 1'b0;
        end else begin
            lb = (tick == 4'b1000) || !(tick inside {4'b0001, 4'b0010, 4'b0100});
            if (in_imm) begin
                if (tick == 4'b0100 || lb) begin
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
                    check("imm_word", {23'd0, din}, {23'd0, e});
                    in_imm = 1'b0;
                end
            end else if (lb && din != 9'h000) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h000;
                check("issue_word", {23'd0, din}, {23'd0, e});
                in_imm = imm_op(e[8:6]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset held while ticks cycle
        for (int i = 0; i < 12; i++) begin
            step();
            check("reset_din", {23'd0, din}, 32'd0);
        end
        check("reset_empty", {31'd0, empty}, 32'd1);
        check("reset_full", {31'd0, full}, 32'd0);
        check("reset_issued", {16'd0, issued}, 32'd0);
        check("reset_count", {28'd0, count}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // single non-immediate instruction
        wait_tick(4'b0001);
        exp_q.push_back(9'h04A);
        push(9'h04A);
        wait_tick(4'b1000);
        step();
        check("add_issued", {16'd0, issued}, 32'd1);
        check("add_count", {28'd0, count}, 32'd0);
        check("add_din_nop", {23'd0, din}, 32'd0);

        // movi held back until its immediate arrives
        exp_q.push_back(9'h1D8);
        exp_q.push_back(9'h005);
        push(9'h1D8);
        steps(8);
        check("partial_din_nop", {23'd0, din}, 32'd0);
        check("partial_count", {28'd0, count}, 32'd1);
        check("partial_issued", {16'd0, issued}, 32'd1);
        push(9'h005);
        wait_tick(4'b1000);
        step();
        check("movi_imm_on_din", {23'd0, din}, 32'h005);
        check("movi_imm_count", {28'd0, count}, 32'd1);
        wait_tick(4'b0100);
        step();
        check("movi_count", {28'd0, count}, 32'd0);
        check("movi_issued", {16'd0, issued}, 32'd2);
        check("movi_din_nop", {23'd0, din}, 32'd0);

        // fill with tick frozen, then overflow
        tick_run = 1'b0;
        tick = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(9'h050 + 9'(i));
            push(9'h050 + 9'(i));
        end
        check("fill_full", {31'd0, full}, 32'd1);
        check("fill_no_overflow", {31'd0, overflow}, 32'd0);
        push(9'h058);
        check("over_overflow", {31'd0, overflow}, 32'd1);
        check("over_count", {28'd0, count}, 32'd8);
        tick_run = 1'b1;
        tick = 4'b1000;
        exp_q.push_back(9'h060);
        push(9'h060);
        check("full_pushpop_count", {28'd0, count}, 32'd8);
        check("full_pushpop_issued", {16'd0, issued}, 32'd3);
        check("full_pushpop_overflow", {31'd0, overflow}, 32'd1);
        steps(36);
        check("drain_count", {28'd0, count}, 32'd0);
        check("drain_issued", {16'd0, issued}, 32'd11);
        check("drain_empty", {31'd0, empty}, 32'd1);
        check("drain_overflow", {31'd0, overflow}, 32'd1);

        // reset in the middle of an immediate-bearing instruction
        wait_tick(4'b0001);
        exp_q.push_back(9'h1C0);
        push(9'h1C0);
        push(9'h003);
        push(9'h04A);
        push(9'h04B);
        step();
        check("midrst_pre_count", {28'd0, count}, 32'd3);
        check("midrst_pre_din", {23'd0, din}, 32'h003);
        rst = 1'b1;
        #1;
        check("midrst_count", {28'd0, count}, 32'd0);
        check("midrst_din", {23'd0, din}, 32'd0);
        check("midrst_empty", {31'd0, empty}, 32'd1);
        check("midrst_issued", {16'd0, issued}, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        steps(2);
        rst = 1'b0;

        // movi R0,#3; movi R1,#4; add R0,R1; sub R0,R1
        wait_tick(4'b0001);
        exp_q.push_back(9'h1C0); exp_q.push_back(9'h003);
        exp_q.push_back(9'h1C8); exp_q.push_back(9'h004);
        exp_q.push_back(9'h041); exp_q.push_back(9'h0C1);
        push(9'h1C0); push(9'h003); push(9'h1C8);
        push(9'h004); push(9'h041); push(9'h0C1);
        steps(24);
        check("prog_issued", {16'd0, issued}, 32'd4);
        check("prog_count", {28'd0, count}, 32'd0);
        check("prog_din_nop", {23'd0, din}, 32'd0);

        // a non-one-hot tick acts as a load boundary
        tick_run = 1'b0;
        tick = 4'b0000;
        exp_q.push_back(9'h04A);
        push(9'h04A);
        check("badtick_count_pre", {28'd0, count}, 32'd1);
        step();
        check("badtick_issued", {16'd0, issued}, 32'd5);
        check("badtick_count", {28'd0, count}, 32'd0);

        step();
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
